// File: rtl/axi_m2_phase_flip_if.sv
// AXI-stream bundle for the phase-flip stage: valid/ready handshake, packed I/Q data, tlast, optional tuser.
// Latency: none; this file only declares wires and modports.
// Backpressure: tready flows from slave to master; tuser exists only when PHASE_FLIP_TUSER_EN is defined.
interface axi_m2_phase_flip_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 12
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
`ifdef PHASE_FLIP_TUSER_EN
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
`else
    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
`endif
endinterface

// File: rtl/axi_m2_phase_flip.sv
// Post-FFT sign correction for the M/2 channelizer: negates I/Q of odd bins on odd frames; PHASE_FLIP_TUSER_EN adds tuser.
// Latency: 2 clocks from input accept to m_axis.tvalid with m_axis.tready held high.
// Backpressure: 2-stage pipeline; s_axis.tready drops only when both stages are full and m_axis.tready is low.
module axi_m2_phase_flip #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOG2   = 11
) (
    input  logic                clk,
    input  logic                sync_reset,
    input  logic [3:0]          fft_size,
    axi_m2_phase_flip_if.slave  s_axis,
    axi_m2_phase_flip_if.master m_axis
);
    localparam int HALF   = DATA_WIDTH / 2;
    localparam int USER_W = MAX_LOG2 + 1;

    logic [MAX_LOG2-1:0]   r_bin_cnt;
    logic                  r_frame_par;
    logic [3:0]            r_size;
    logic [3:0]            w_size_in;
    logic [3:0]            w_size_cur;
    logic [MAX_LOG2-1:0]   w_last_bin;
    logic                  w_at_last;
    logic                  w_s_rdy;
    logic                  w_accept;
    logic                  w_s1_load;
    logic                  w_neg;

    logic                  r_occ0;
    logic                  r_occ1;
    logic [DATA_WIDTH-1:0] r_s0_dat;
    logic                  r_s0_neg;
    logic                  r_s0_last;
    logic [DATA_WIDTH-1:0] r_s1_dat;
    logic                  r_s1_last;
`ifdef PHASE_FLIP_TUSER_EN
    logic [USER_W-1:0]     r_s0_user;
    logic [USER_W-1:0]     r_s1_user;
`endif

    // Negation that saturates the most-negative code to the most-positive one.
    function automatic logic [HALF-1:0] f_sat_neg(input logic [HALF-1:0] x);
        if (x == {1'b1, {(HALF-1){1'b0}}}) begin
            f_sat_neg = ~x;
        end else begin
            f_sat_neg = -x;
        end
    endfunction

    // Clamp the requested log2 size into the supported range.
    always_comb begin
        w_size_in = fft_size;
        if (fft_size < 4'd3) begin
            w_size_in = 4'd3;
        end else if (fft_size > 4'(MAX_LOG2)) begin
            w_size_in = 4'(MAX_LOG2);
        end
    end

    // At a frame boundary the live size applies; mid-frame the latched one holds.
    assign w_size_cur = (r_bin_cnt == '0) ? w_size_in : r_size;
    assign w_last_bin = ~({MAX_LOG2{1'b1}} << w_size_cur);
    assign w_at_last  = (r_bin_cnt == w_last_bin);
    assign w_neg      = r_frame_par & r_bin_cnt[0];

    assign w_s1_load  = m_axis.tready | ~r_occ1;
    assign w_s_rdy    = ~(r_occ0 & r_occ1) | m_axis.tready;
    assign w_accept   = s_axis.tvalid & w_s_rdy;

    assign s_axis.tready = w_s_rdy;
    assign m_axis.tvalid = r_occ1;
    assign m_axis.tdata  = r_s1_dat;
    assign m_axis.tlast  = r_s1_last;
`ifdef PHASE_FLIP_TUSER_EN
    assign m_axis.tuser  = r_s1_user;
`endif

    // Bin counter, frame parity and size latch; wrap and parity toggle on the last accept.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_bin_cnt   <= '0;
            r_frame_par <= 1'b0;
            r_size      <= 4'd3;
        end else begin
            if (r_bin_cnt == '0) begin
                r_size <= w_size_in;
            end
            if (w_accept) begin
                if (w_at_last) begin
                    r_bin_cnt   <= '0;
                    r_frame_par <= ~r_frame_par;
                end else begin
                    r_bin_cnt <= r_bin_cnt + MAX_LOG2'(1);
                end
            end
        end
    end

    // Stage 0: capture the accepted sample with its negate/last tags.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_occ0    <= 1'b0;
            r_s0_dat  <= '0;
            r_s0_neg  <= 1'b0;
            r_s0_last <= 1'b0;
`ifdef PHASE_FLIP_TUSER_EN
            r_s0_user <= '0;
`endif
        end else if (w_accept) begin
            r_occ0    <= 1'b1;
            r_s0_dat  <= s_axis.tdata;
            r_s0_neg  <= w_neg;
            r_s0_last <= w_at_last;
`ifdef PHASE_FLIP_TUSER_EN
            r_s0_user <= {r_frame_par, r_bin_cnt};
`endif
        end else if (w_s1_load) begin
            r_occ0 <= 1'b0;
        end
    end

    // Stage 1: apply the sign correction and hold outputs while downstream stalls.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_occ1    <= 1'b0;
            r_s1_dat  <= '0;
            r_s1_last <= 1'b0;
`ifdef PHASE_FLIP_TUSER_EN
            r_s1_user <= '0;
`endif
        end else if (w_s1_load) begin
            r_occ1 <= r_occ0;
            if (r_occ0) begin
                r_s1_dat  <= r_s0_neg ? {f_sat_neg(r_s0_dat[DATA_WIDTH-1:HALF]), f_sat_neg(r_s0_dat[HALF-1:0])}
                                      : r_s0_dat;
                r_s1_last <= r_s0_last;
`ifdef PHASE_FLIP_TUSER_EN
                r_s1_user <= r_s0_user;
`endif
            end
        end
    end

endmodule

// File: tb/tb_axi_m2_phase_flip.sv
// Self-checking bench for axi_m2_phase_flip: scoreboard of expected beats against observed output transfers.
// Latency: checks the 2-clock accept-to-valid delay on the first beat of a frame.
// Backpressure: random downstream ready with a stall-stability monitor.
module tb_axi_m2_phase_flip;
    localparam int DW = 32;
    localparam int ML = 11;
    localparam int UW = ML + 1;

    typedef struct {
        logic [DW-1:0] dat;
        logic          last;
        logic [UW-1:0] user;
        int            cyc;
    } beat_t;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic [3:0] fft_size;

    axi_m2_phase_flip_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if();
    axi_m2_phase_flip_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if();

    axi_m2_phase_flip #(.DATA_WIDTH(DW), .MAX_LOG2(ML)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .fft_size   (fft_size),
        .s_axis     (s_if),
        .m_axis     (m_if)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    stall_err = 0;
    int    mdl_bin = 0;
    logic  mdl_par = 1'b0;
    int    mdl_size = 3;
    bit    bp_done;

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    logic          prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: record every transfer and flag any change while stalled.
    always @(negedge clk) begin
        beat_t o;
        if (sync_reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_dat || m_if.tlast !== prev_last))
                stall_err <= stall_err + 1;
            if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
                o.dat  = m_if.tdata;
                o.last = m_if.tlast;
`ifdef PHASE_FLIP_TUSER_EN
                o.user = m_if.tuser;
`else
                o.user = '0;
`endif
                o.cyc  = cyc;
                obs_q.push_back(o);
            end
            prev_stall <= m_if.tvalid && !m_if.tready;
            prev_dat   <= m_if.tdata;
            prev_last  <= m_if.tlast;
        end
    end

    function automatic int clamp(input int v);
        if (v < 3) return 3;
        if (v > ML) return ML;
        return v;
    endfunction

    function automatic logic [15:0] sneg(input logic [15:0] x);
        int v;
        v = -int'($signed(x));
        if (v > 32767) v = 32767;
        return 16'(v);
    endfunction

    function automatic logic [DW-1:0] mk(input int k);
        return {k[15:0], k[15:0]};
    endfunction

    // Golden model: called once per accepted input beat.
    task automatic model_accept(input logic [DW-1:0] d);
        beat_t b;
        logic  neg;
        if (mdl_bin == 0) mdl_size = clamp(int'(fft_size));
        neg    = mdl_par && (mdl_bin % 2 == 1);
        b.dat  = neg ? {sneg(d[31:16]), sneg(d[15:0])} : d;
        b.last = (mdl_bin == (1 << mdl_size) - 1);
        b.user = {mdl_par, ML'(mdl_bin)};
        b.cyc  = cyc;
        exp_q.push_back(b);
        if (b.last) begin
            mdl_bin = 0;
            mdl_par = ~mdl_par;
        end else begin
            mdl_bin++;
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        forever begin
            @(negedge clk);
            if (s_if.tready === 1'b1) begin
                model_accept(d);
                break;
            end
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: tready=%b after %0d cycles, want 1", s_if.tready, n);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        m_if.tready = 1'b1;
        while (obs_q.size() < exp_q.size() && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input logic [3:0] size);
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        fft_size    = size;
        sync_reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sync_reset = 1'b0;
        mdl_bin = 0;
        mdl_par = 1'b0;
        exp_q.delete();
        obs_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;
        fft_size    = 4'd3;
        sync_reset  = 1'b1;
        #2;
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_if.tvalid); end
        checks++; if (m_if.tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_if.tdata); end
        checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_if.tlast); end
        checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready: got %b want 1", s_if.tready); end
`ifdef PHASE_FLIP_TUSER_EN
        checks++; if (m_if.tuser !== '0) begin errors++; $display("FAIL reset_tuser: got %h want 0", m_if.tuser); end
`endif
    endtask

    task automatic test_passthrough();
        beat_t e, o;
        do_reset(4'd3);
        for (int k = 0; k < 8; k++) send(mk(k));
        wait_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL pass_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            checks++;
            if (obs_q[0].cyc - exp_q[0].cyc != 2) begin errors++; $display("FAIL pass_latency: got %0d want 2", obs_q[0].cyc - exp_q[0].cyc); end
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].last !== (i == 7) || obs_q[i].dat !== mk(i)) begin
                errors++; $display("FAIL pass_beat[%0d]: got dat=%h last=%b want dat=%h last=%b", i, obs_q[i].dat, obs_q[i].last, mk(i), (i == 7));
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
`ifdef PHASE_FLIP_TUSER_EN
            checks++;
            if (o.user !== e.user) begin errors++; $display("FAIL pass_tuser: got %h want %h", o.user, e.user); end
`endif
        end
    endtask

    task automatic test_odd_flip();
        beat_t e, o;
        for (int k = 0; k < 8; k++) send(mk(k + 100));
        for (int k = 0; k < 8; k++) send(mk(k + 200));
        wait_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL flip_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        if (obs_q.size() >= 16) begin
            checks++; if (obs_q[1].dat !== 32'hFF9BFF9B) begin errors++; $display("FAIL flip_bin1: got %h want ff9bff9b", obs_q[1].dat); end
            checks++; if (obs_q[2].dat !== 32'h00660066) begin errors++; $display("FAIL flip_bin2: got %h want 00660066", obs_q[2].dat); end
            checks++; if (obs_q[3].dat !== 32'hFF99FF99) begin errors++; $display("FAIL flip_bin3: got %h want ff99ff99", obs_q[3].dat); end
            checks++; if (obs_q[15].dat !== 32'h00CF00CF || obs_q[15].last !== 1'b1) begin
                errors++; $display("FAIL even_frame_bin7: got %h last=%b want 00cf00cf last=1", obs_q[15].dat, obs_q[15].last);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.dat !== e.dat || o.last !== e.last) begin
                errors++; $display("FAIL flip_beat: got dat=%h last=%b want dat=%h last=%b", o.dat, o.last, e.dat, e.last);
            end
        end
    endtask

    task automatic test_saturation();
        beat_t e, o;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) send(32'h80007FFF);
            else if (k == 3) send(32'h7FFF8000);
            else send(mk(k + 1));
        end
        wait_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL sat_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        if (obs_q.size() >= 4) begin
            checks++; if (obs_q[1].dat !== 32'h7FFF8001) begin errors++; $display("FAIL sat_bin1: got %h want 7fff8001", obs_q[1].dat); end
            checks++; if (obs_q[3].dat !== 32'h80017FFF) begin errors++; $display("FAIL sat_bin3: got %h want 80017fff", obs_q[3].dat); end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.dat !== e.dat || o.last !== e.last) begin
                errors++; $display("FAIL sat_beat: got dat=%h last=%b want dat=%h last=%b", o.dat, o.last, e.dat, e.last);
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t e, o;
        int    s0;
        do_reset(4'd4);
        s0 = stall_err;
        bp_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 64; k++) begin
                    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                    send($urandom);
                end
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    m_if.tready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        wait_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        checks++;
        if (stall_err != s0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_err - s0); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.dat !== e.dat || o.last !== e.last) begin
                errors++; $display("FAIL bp_beat: got dat=%h last=%b want dat=%h last=%b", o.dat, o.last, e.dat, e.last);
            end
`ifdef PHASE_FLIP_TUSER_EN
            checks++;
            if (o.user !== e.user) begin errors++; $display("FAIL bp_tuser: got %h want %h", o.user, e.user); end
`endif
        end
    endtask

    task automatic test_size_change();
        beat_t e, o;
        do_reset(4'd3);
        for (int k = 0; k < 5; k++) send(mk(k));
        fft_size = 4'd4;
        for (int k = 5; k < 24; k++) send(mk(k));
        wait_drain();
        checks++;
        if (obs_q.size() != 24) begin errors++; $display("FAIL size_count: got %0d want 24", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].last !== (i == 7 || i == 23)) begin
                errors++; $display("FAIL size_tlast[%0d]: got %b want %b", i, obs_q[i].last, (i == 7 || i == 23));
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.dat !== e.dat || o.last !== e.last) begin
                errors++; $display("FAIL size_beat: got dat=%h last=%b want dat=%h last=%b", o.dat, o.last, e.dat, e.last);
            end
        end
    endtask

    task automatic test_clamp();
        do_reset(4'd1);
        for (int k = 0; k < 8; k++) send(mk(k));
        wait_drain();
        checks++;
        if (obs_q.size() != 8) begin errors++; $display("FAIL clamp_count: got %0d want 8", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].last !== (i == 7)) begin errors++; $display("FAIL clamp_tlast[%0d]: got %b want %b", i, obs_q[i].last, (i == 7)); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_mid_reset();
        beat_t e, o;
        do_reset(4'd3);
        for (int k = 0; k < 13; k++) send(mk(k + 1));
        wait_drain();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.dat !== e.dat || o.last !== e.last) begin
                errors++; $display("FAIL prereset_beat: got dat=%h last=%b want dat=%h last=%b", o.dat, o.last, e.dat, e.last);
            end
        end
        m_if.tready = 1'b0;
        send(mk(50));
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL midrst_pending: got tvalid=%b want 1", m_if.tvalid); end
        #2 sync_reset = 1'b1;
        #1;
        checks++;
        if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid_drop: got %b want 0", m_if.tvalid); end
        @(posedge clk); #1;
        sync_reset = 1'b0;
        mdl_bin = 0;
        mdl_par = 1'b0;
        exp_q.delete();
        obs_q.delete();
        m_if.tready = 1'b1;
        @(posedge clk); #1;
        send(32'h0005FFFB);
        send(32'h0009FFF7);
        wait_drain();
        checks++;
        if (obs_q.size() != 2) begin errors++; $display("FAIL midrst_count: got %0d want 2", obs_q.size()); end
        if (obs_q.size() >= 2) begin
            checks++; if (obs_q[0].dat !== 32'h0005FFFB) begin errors++; $display("FAIL midrst_bin0: got %h want 0005fffb", obs_q[0].dat); end
            checks++; if (obs_q[1].dat !== 32'h0009FFF7) begin errors++; $display("FAIL midrst_bin1: got %h want 0009fff7", obs_q[1].dat); end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.dat !== e.dat || o.last !== e.last) begin
                errors++; $display("FAIL midrst_beat: got dat=%h last=%b want dat=%h last=%b", o.dat, o.last, e.dat, e.last);
            end
`ifdef PHASE_FLIP_TUSER_EN
            checks++;
            if (o.user !== e.user) begin errors++; $display("FAIL midrst_tuser: got %h want %h", o.user, e.user); end
`endif
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
`ifdef PHASE_FLIP_TUSER_EN
        s_if.tuser  = '0;
`endif
        m_if.tready = 1'b0;
        test_reset();
        test_passthrough();
        test_odd_flip();
        test_saturation();
        test_backpressure();
        test_size_change();
        test_clamp();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
